// File: rtl/dm_pkg.sv
// Shared data-memory encodings and defaults, also imported by the Controller.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_RSVD = 2'b11
  } store_t;

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_BYTE = 2'b01,
    LD_HALF = 2'b10,
    LD_RSVD = 2'b11
  } load_t;

  localparam int DM_DEPTH_WORDS = 3072;
  localparam int DM_ADDR_BITS   = 14;

endpackage

// File: rtl/dm_byte_mask.sv
// Store lane-mask generation: merges right-aligned store data into the old word
// and flags misaligned stores (o_valid=0) so the caller can drop them.
import dm_pkg::*;

module dm_byte_mask (
  input  logic [1:0]  i_store_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_new_word,
  output logic        o_valid
);

  logic [31:0] w_mask;
  logic [31:0] w_data;

  always_comb begin
    w_mask  = '0;
    w_data  = '0;
    o_valid = 1'b0;
    case (store_t'(i_store_type))
      ST_BYTE: begin
        w_mask  = 32'h0000_00FF << {i_addr_lo, 3'b000};
        w_data  = {4{i_write_data[7:0]}};
        o_valid = 1'b1;
      end
      ST_HALF: begin
        w_mask  = i_addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_data  = {2{i_write_data[15:0]}};
        o_valid = ~i_addr_lo[0];
      end
      default: begin
        // reserved encoding stores a full word
        w_mask  = 32'hFFFF_FFFF;
        w_data  = i_write_data;
        o_valid = (i_addr_lo == 2'b00);
      end
    endcase
  end

  assign o_new_word = (i_old_word & ~w_mask) | (w_data & w_mask);

endmodule

// File: rtl/data_memory.sv
// Data memory: combinational extended loads, clocked byte/half/word stores,
// async clear on reset. Define DM_WRITE_LOG_EN to print each performed write.
import dm_pkg::*;

module data_memory #(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int ADDR_BITS   = DM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_enable,
  input  logic [1:0]  store_type,
  input  logic [1:0]  load_type,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [31:0] pc,
  output logic [31:0] read_data
);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [ADDR_BITS-1:0] w_offs;
  logic [ADDR_BITS-3:0] w_idx;
  logic                 w_in_range;
  logic [31:0]          w_rd_word;
  logic [31:0]          w_new;
  logic                 w_align_ok;
  logic                 w_wr_ok;
  logic [31:0]          w_byte_sh;
  logic [15:0]          w_half;

  assign w_offs     = addr[ADDR_BITS-1:0];
  assign w_idx      = addr[ADDR_BITS-1:2];
  assign w_in_range = ({{(32-ADDR_BITS){1'b0}}, w_offs} < 32'(DEPTH_WORDS * 4));
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'h0;

  dm_byte_mask u_mask (
    .i_store_type (store_type),
    .i_addr_lo    (addr[1:0]),
    .i_old_word   (w_rd_word),
    .i_write_data (write_data),
    .o_new_word   (w_new),
    .o_valid      (w_align_ok)
  );

  assign w_wr_ok = DM_enable & w_align_ok & w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_idx] <= w_new;
    end
  end

  assign w_byte_sh = w_rd_word >> {addr[1:0], 3'b000};
  assign w_half    = addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  // Read path sees the pre-edge array, so same-cycle read-after-write returns old data.
  always_comb begin
    read_data = 32'h0;
    if (!reset && w_in_range) begin
      case (load_t'(load_type))
        LD_BYTE: read_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
        LD_HALF: if (!addr[0]) read_data = {{16{w_half[15]}}, w_half};
        default: if (addr[1:0] == 2'b00) read_data = w_rd_word;
      endcase
    end
  end

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (!reset && w_wr_ok)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_new);
  end
  logic w_unused;
  assign w_unused = ^addr[31:ADDR_BITS];
`else
  logic w_unused;
  assign w_unused = ^{pc, addr[31:ADDR_BITS]};
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against a byte-addressed reference model.
module tb_data_memory;

  localparam int NBYTES = 3072 * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        DM_enable;
  logic [1:0]  store_type;
  logic [1:0]  load_type;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] pc;
  logic [31:0] read_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mb [NBYTES];

  data_memory dut (
    .clk        (clk),
    .reset      (reset),
    .DM_enable  (DM_enable),
    .store_type (store_type),
    .load_type  (load_type),
    .addr       (addr),
    .write_data (write_data),
    .pc         (pc),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  function automatic int unsigned sz_of(input logic [1:0] t);
    return (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] lt);
    int unsigned off = int'(a[13:0]);
    int unsigned n   = sz_of(lt);
    logic [31:0] v = 0;
    if (off >= NBYTES || (off % n) != 0) return 32'h0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(mb[off + k]);
    if (n == 1) v = {{24{v[7]}}, v[7:0]};
    if (n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] st, input logic [31:0] d);
    int unsigned off = int'(a[13:0]);
    int unsigned n   = sz_of(st);
    if (off >= NBYTES || (off % n) != 0) return;
    for (int k = 0; k < n; k++) mb[off + k] = d[8*k +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] st, input logic [31:0] d);
    @(negedge clk);
    addr = a; store_type = st; write_data = d; DM_enable = 1'b1; pc = pc + 4;
    @(posedge clk);
    m_store(a, st, d);
    #1 DM_enable = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] lt, output logic [31:0] v);
    @(negedge clk);
    addr = a; load_type = lt;
    #1 v = read_data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1 chk("reset_read", read_data, 32'h0);
    @(negedge clk) reset = 1'b0;
    m_clear();
    do_read(32'h4, 2'b00, v); chk("post_reset_lw4", v, 32'h0);
  endtask

  task automatic test_word();
    logic [31:0] v;
    do_write(32'h4, 2'b00, 32'h12345678);
    do_read(32'h4, 2'b00, v); chk("lw4", v, 32'h12345678);
    chk("lw4_model", v, m_load(32'h4, 2'b00));
  endtask

  task automatic test_byte();
    logic [31:0] v;
    do_write(32'h6, 2'b01, 32'h000000AB);
    do_read(32'h6, 2'b01, v); chk("lb6", v, 32'hFFFFFFAB);
    do_read(32'h4, 2'b00, v); chk("lw4_after_sb", v, 32'h12AB5678);
  endtask

  task automatic test_half();
    logic [31:0] v;
    do_write(32'hA, 2'b10, 32'h00008001);
    do_read(32'hA, 2'b10, v); chk("lhA", v, 32'hFFFF8001);
    do_read(32'h8, 2'b10, v); chk("lh8", v, 32'h0);
    do_read(32'h8, 2'b00, v); chk("lw8", v, 32'h80010000);
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    do_write(32'h3, 2'b10, 32'hFFFFFFFF);
    do_write(32'h3000, 2'b00, 32'hCAFEF00D);
    do_read(32'h0, 2'b00, v); chk("lw0_unchanged", v, 32'h0);
    do_read(32'h4, 2'b00, v); chk("lw4_unchanged", v, 32'h12AB5678);
    do_read(32'h3000, 2'b00, v); chk("lw3000_oor", v, 32'h0);
    do_read(32'h6, 2'b00, v); chk("lw_misaligned", v, 32'h0);
    do_read(32'hB, 2'b10, v); chk("lh_misaligned", v, 32'h0);
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    addr = 32'h10; store_type = 2'b00; load_type = 2'b00;
    write_data = 32'hDEADBEEF; DM_enable = 1'b1; pc = pc + 4;
    #1 chk("same_cycle_old", read_data, 32'h0);
    @(posedge clk);
    m_store(32'h10, 2'b00, 32'hDEADBEEF);
    #1 DM_enable = 1'b0;
    chk("next_cycle_new", read_data, 32'hDEADBEEF);
  endtask

  task automatic test_random();
    logic [31:0] a, ra, d, exp;
    logic [1:0]  st, lt;
    logic        we;
    int          errs = 0;
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'h2FC0 + $urandom_range(0, 127) : $urandom_range(0, 63);
      ra = ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 63));
      st = 2'($urandom_range(0, 3));
      lt = 2'($urandom_range(0, 3));
      d  = $urandom;
      we = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      addr = we ? a : ra; store_type = st; load_type = lt; write_data = d;
      DM_enable = we; pc = pc + 4;
      exp = m_load(addr, lt);
      #1;
      if (read_data !== exp) begin
        errs++;
        if (errs <= 5) $display("FAIL random_read[%0d] @%h lt=%0d: got %h expected %h", i, addr, lt, read_data, exp);
      end
      @(posedge clk);
      if (we) m_store(a, st, d);
      #1 DM_enable = 1'b0;
    end
    total_cnt++;
    if (errs == 0) pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_write(32'h20, 2'b00, 32'h11112222);
    do_write(32'h24, 2'b00, 32'h33334444);
    do_write(32'h2FFC, 2'b00, 32'h55556666);
    do_read(32'h2FFC, 2'b00, v); chk("pre_reset_top", v, 32'h55556666);
    @(negedge clk);
    addr = 32'h28; store_type = 2'b00; write_data = 32'h77778888; DM_enable = 1'b1;
    #2 reset = 1'b1;
    m_clear();
    #1 chk("reset_async_read28", read_data, 32'h0);
    addr = 32'h20; load_type = 2'b00;
    #1 chk("reset_async_read20", read_data, 32'h0);
    @(posedge clk);
    #1 DM_enable = 1'b0;
    @(negedge clk) reset = 1'b0;
    do_read(32'h20, 2'b00, v); chk("after_reset_20", v, m_load(32'h20, 2'b00));
    do_read(32'h24, 2'b00, v); chk("after_reset_24", v, 32'h0);
    do_read(32'h2FFC, 2'b00, v); chk("after_reset_top", v, 32'h0);
    do_read(32'h28, 2'b00, v); chk("write_under_reset", v, 32'h0);
    do_read(32'h10, 2'b00, v); chk("after_reset_10", v, 32'h0);
  endtask

  initial begin
    reset = 1'b1; DM_enable = 1'b0; store_type = 2'b00; load_type = 2'b00;
    addr = 32'h0; write_data = 32'h0; pc = 32'h0000_3000;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, number of 32-bit words (byte range 0x0000..0x2FFF).
REQ-002 SHALL have parameter ADDR_BITS, default 14, number of low address bits decoded.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DM_enable  input  1  write request for the current cycle.
REQ-006 SHALL have port store_type  input  2  00 word, 01 byte, 10 half, 11 reserved.
REQ-007 SHALL have port load_type  input  2  00 word, 01 byte signed, 10 half signed, 11 reserved.
REQ-008 SHALL have port addr  input  32  byte address from the ALU.
REQ-009 SHALL have port write_data  input  32  store data from the GRF rt port, right-aligned.
REQ-010 SHALL have port pc  input  32  PC of the current instruction, for the write log only.
REQ-011 SHALL have port read_data  output  32  load result, already extended, for GRF write-back.

Function
REQ-012 SHALL read combinationally: read_data reflects addr, load_type and array contents in the same cycle, with no added latency.
REQ-013 SHALL write on the rising edge of clk when DM_enable=1 and reset=0; a write is visible to reads from the following cycle.
REQ-014 SHALL index word addr[ADDR_BITS-1:2]; addr at or above DEPTH_WORDS*4 SHALL be out of range.
REQ-015 SHALL, for store_type 01, replace only byte lane addr[1:0] with write_data[7:0].
REQ-016 SHALL, for store_type 10, replace lane addr[1]*2 halfword with write_data[15:0].
REQ-017 SHALL, for store_type 00 or 11, replace the full word with write_data.
REQ-018 SHALL, for load_type 01, return the addressed byte sign-extended to 32 bits.
REQ-019 SHALL, for load_type 10, return the addressed halfword sign-extended to 32 bits.
REQ-020 SHALL, for load_type 00 or 11, return the full word.
REQ-021 SHALL ignore writes (array unchanged) that are misaligned (half with addr[0]=1, word with addr[1:0]!=0) or out of range.
REQ-022 SHALL return 32'h0 for misaligned or out-of-range reads.
REQ-023 SHALL, when a read and a write target the same word in one cycle, return the pre-write contents.

Reset
REQ-024 SHALL clear every word to 32'h0 immediately on reset=1, independent of clk.
REQ-025 SHALL block writes while reset=1; read_data SHALL be 32'h0 throughout reset.
REQ-026 SHALL, when reset asserts in the cycle of a pending write, discard that write.

Configuration
REQ-027 SHALL, with DM_WRITE_LOG_EN defined, $display "@%h: *%h <= %h" (pc, word-aligned address, resulting full word) at every performed write.
REQ-028 SHALL, without DM_WRITE_LOG_EN, emit no output and include no simulation-only statements.

Structure
REQ-029 SHALL take store/load type encodings and DEPTH_WORDS default from the shared package dm_pkg, which the Controller also uses.
REQ-030 SHALL place lane-mask and merged-word generation in sub-module dm_byte_mask (inputs store_type, addr[1:0], old word, write_data; outputs new word and a valid flag).

Verification
REQ-031 SHALL cover: reset, then sw 0x12345678 @0x0004, lw @0x0004 -> 0x12345678; log "@<pc>: *00000004 <= 12345678".
REQ-032 SHALL cover: sb 0x000000AB @0x0006 on word 0x12345678, lb @0x0006 -> 0xFFFFFFAB, lw @0x0004 -> 0x12AB5678.
REQ-033 SHALL cover: sh 0x00008001 @0x000A, lh @0x000A -> 0xFFFF8001, lh @0x0008 -> 0x00000000.
REQ-034 SHALL cover: sh @0x0003 and sw @0x3000 -> array unchanged, no log line; lw @0x3000 -> 0x0.
REQ-035 SHALL cover: same-cycle sw 0xDEADBEEF and lw @0x0010 -> read 0x0 that cycle, 0xDEADBEEF next cycle.
REQ-036 SHALL cover: reset asserted mid-cycle between edges after several writes -> all reads 0x0 at once, and write under reset ignored.
